// File: rtl/lampFPU_pkg.sv
// Shared lampFPU definitions for the square-root controller:
// float constants, controller FSM state and rounding helper.
package lampFPU_pkg;

  localparam int unsigned LAMP_BIAS = 127;
  localparam logic [15:0] LAMP_QNAN = 16'h7FC0;
  localparam logic [15:0] LAMP_INF  = 16'h7F80;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PACK
  } sqrt_state_e;

  function automatic logic rne_up(
    input logic lsb,
    input logic g,
    input logic s
  );
    return g & (s | lsb);
  endfunction

endpackage

// File: rtl/lamp_fpu_sqrt_norm_round.sv
// Normalizes the fractional core result, rounds to nearest-even
// and packs a LAMP float, or passes a pre-resolved special through.
module lamp_fpu_sqrt_norm_round
  import lampFPU_pkg::*;
#(
  parameter int unsigned EW = 8,
  parameter int unsigned FW = 7
) (
  input  logic [2*(1+FW)-1:0] res_i,
  input  logic [EW:0]         eb_i,
  input  logic                spec_i,
  input  logic [EW+FW:0]      spec_res_i,
  output logic [EW+FW:0]      result_o
);

  localparam int unsigned RW = 2 * (1 + FW);
  localparam logic [EW:0] ONE = (EW + 1)'(1);

  logic [RW-1:0] n;
  logic [EW:0]   e;
  logic [EW:0]   e_r;
  logic [FW:0]   f_r;
  logic          up;
  logic          unused_nr;

  always_comb begin
    n = res_i[RW-1] ? res_i : (res_i << 1);
    e = res_i[RW-1] ? eb_i : eb_i - ONE;
    up = rne_up(n[FW+1], n[FW], |n[FW-1:0]);
    // carry out of the fraction lands in f_r[FW] and bumps the exponent
    f_r = {1'b0, n[RW-2:FW+1]} + {{FW{1'b0}}, up};
    e_r = e + {{EW{1'b0}}, f_r[FW]};
    result_o = spec_i ? spec_res_i
                      : {1'b0, e_r[EW-1:0], f_r[FW-1:0]};
    unused_nr = n[RW-1] ^ e_r[EW];
  end

endmodule

// File: rtl/lamp_fpu_sqrt_ctrl.sv
// Operation-level controller for the lampFPU sqrt / inverse-sqrt path:
// special-operand handling, core handshake, timeout and result packing.
module lamp_fpu_sqrt_ctrl
  import lampFPU_pkg::*;
#(
  parameter int unsigned LAMP_FLOAT_E_DW = 8,
  parameter int unsigned LAMP_FLOAT_F_DW = 7,
  parameter int unsigned CORE_TIMEOUT    = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   doSqrt_i,
  input  logic                                   doInvSqrt_i,
  input  logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW:0] op_i,
  output logic                                   busy_o,
  output logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW:0] result_o,
  output logic                                   valid_o,
  output logic                                   invalid_o,
  output logic                                   divZero_o,
  output logic                                   timeout_o,
  output logic                                   core_doSqrt_o,
  output logic                                   core_doInvSqrt_o,
  output logic [LAMP_FLOAT_F_DW:0]               core_s_o,
  input  logic [2*LAMP_FLOAT_F_DW+1:0]           core_result_i,
  input  logic                                   core_valid_i
);

  localparam int unsigned EW  = LAMP_FLOAT_E_DW;
  localparam int unsigned FW  = LAMP_FLOAT_F_DW;
  localparam int unsigned W   = 1 + EW + FW;
  localparam int unsigned RW  = 2 * (1 + FW);
  localparam int unsigned EBW = EW + 1;
  localparam int unsigned CW  = $clog2(CORE_TIMEOUT) + 1;

  localparam logic [W-1:0]   QNAN  = W'(LAMP_QNAN);
  localparam logic [W-1:0]   INF   = W'(LAMP_INF);
  localparam logic [EBW-1:0] EOFS  = EBW'(LAMP_BIAS + 1);
  localparam logic [EBW-1:0] ETOP  = EBW'(2 * LAMP_BIAS);
  localparam logic [CW-1:0]  CLAST = CW'(CORE_TIMEOUT - 1);
  localparam logic [CW-1:0]  CONE  = CW'(1);

  sqrt_state_e    state_q;
  logic           busy_q, valid_q, cdo_q, cdi_q;
  logic           inv_o_q, dz_o_q, to_o_q;
  logic [W-1:0]   result_q;
  logic [FW:0]    s_q;
  logic [EBW-1:0] eb_q;
  logic [RW-1:0]  cres_q;
  logic [CW-1:0]  cnt_q;
  logic           spec_q, fi_q, fdz_q, fto_q;
  logic [W-1:0]   sres_q;

  logic           sgn, nan, zro, inf, start, inv;
  logic           spec, f_inv, f_dz;
  logic [EW-1:0]  ex;
  logic [FW-1:0]  fr;
  logic [W-1:0]   sres;
  logic [FW:0]    s_n;
  logic [EBW-1:0] half, eb_n;
  logic [W-1:0]   pack_res;

  always_comb begin
    sgn   = op_i[W-1];
    ex    = op_i[W-2:FW];
    fr    = op_i[FW-1:0];
    nan   = (&ex) & (|fr);
    inf   = (&ex) & ~(|fr);
    zro   = ~(|ex);
    start = doSqrt_i | doInvSqrt_i;
    inv   = ~doSqrt_i;
    spec  = 1'b1;
    f_inv = 1'b0;
    f_dz  = 1'b0;
    sres  = QNAN;
    // denormals share the zero path, keeping their sign
    if (nan) f_inv = 1'b1;
    else if (zro && inv) begin
      sres = INF;
      f_dz = 1'b1;
    end
    else if (zro) sres = {sgn, {(W-1){1'b0}}};
    else if (sgn) f_inv = 1'b1;
    else if (inf) sres = inv ? '0 : INF;
    else spec = 1'b0;
    s_n  = ex[0] ? {1'b1, fr} : {2'b01, fr[FW-1:1]};
    half = ({1'b0, ex} + EOFS) >> 1;
    eb_n = inv ? ETOP - half : half;
  end

  lamp_fpu_sqrt_norm_round #(
    .EW(EW),
    .FW(FW)
  ) u_norm_round (
    .res_i     (cres_q),
    .eb_i      (eb_q),
    .spec_i    (spec_q),
    .spec_res_i(sres_q),
    .result_o  (pack_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      cdo_q    <= 1'b0;
      cdi_q    <= 1'b0;
      inv_o_q  <= 1'b0;
      dz_o_q   <= 1'b0;
      to_o_q   <= 1'b0;
      result_q <= '0;
      s_q      <= '0;
      eb_q     <= '0;
      cres_q   <= '0;
      cnt_q    <= '0;
      spec_q   <= 1'b0;
      fi_q     <= 1'b0;
      fdz_q    <= 1'b0;
      fto_q    <= 1'b0;
      sres_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      cdo_q   <= 1'b0;
      cdi_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            spec_q <= spec;
            sres_q <= sres;
            fi_q   <= f_inv;
            fdz_q  <= f_dz;
            fto_q  <= 1'b0;
            cnt_q  <= '0;
            if (spec) begin
              state_q <= S_PACK;
            end else begin
              state_q <= S_ISSUE;
              s_q     <= s_n;
              eb_q    <= eb_n;
              cdo_q   <= ~inv;
              cdi_q   <= inv;
            end
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (core_valid_i) begin
            cres_q  <= core_result_i;
            state_q <= S_PACK;
          end else if (cnt_q == CLAST) begin
            spec_q  <= 1'b1;
            sres_q  <= QNAN;
            fi_q    <= 1'b1;
            fto_q   <= 1'b1;
            state_q <= S_PACK;
          end else begin
            cnt_q <= cnt_q + CONE;
          end
        end
        S_PACK: begin
          result_q <= pack_res;
          inv_o_q  <= fi_q;
          dz_o_q   <= fdz_q;
          to_o_q   <= fto_q;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign result_o         = result_q;
  assign valid_o          = valid_q;
  assign invalid_o        = inv_o_q;
  assign divZero_o        = dz_o_q;
  assign timeout_o        = to_o_q;
  assign core_doSqrt_o    = cdo_q;
  assign core_doInvSqrt_o = cdi_q;
  assign core_s_o         = s_q;

endmodule
